// File: rtl/eprom_reader_if.sv
// Bundles the command, byte-stream and 8755 socket signals of the EPROM
// read-back engine. master = the reader itself, slave = host plus socket.
interface eprom_reader_if;
    // command path
    logic        start;
    logic [10:0] start_addr;
    logic [11:0] count;
    logic        busy;
    logic        done;
    // byte stream to host / compare logic
    logic [7:0]  byte_data;
    logic [10:0] byte_addr;
    logic        byte_valid;
    logic        byte_ready;
    // 8755 socket pins
    logic [10:0] addr_dat;
    logic        ad_oe;
    logic        ale;
    logic        rd_n;
    logic        ce;
    logic [7:0]  data_in;

    modport master (
        input  start, start_addr, count, byte_ready, data_in,
        output busy, done, byte_data, byte_addr, byte_valid,
               addr_dat, ad_oe, ale, rd_n, ce
    );

    modport slave (
        output start, start_addr, count, byte_ready, data_in,
        input  busy, done, byte_data, byte_addr, byte_valid,
               addr_dat, ad_oe, ale, rd_n, ce
    );
endinterface

// File: rtl/eprom_reader.sv
// Read-back engine for an 8755 EPROM on the multiplexed AD bus. For each
// byte it drives the address with ALE, releases AD7-0, strobes RD_N, samples
// the byte and hands it with its address to the host over valid/ready.
// All outputs are registered; each transition loads the values the target
// state needs, so the socket pins never glitch between states.
module eprom_reader #(
    parameter int ALE_CYC = 2,
    parameter int RD_CYC  = 4
) (
    input  logic           clk,
    input  logic           rst,
    eprom_reader_if.master bus
);
    localparam int MAX_CYC = (ALE_CYC > RD_CYC) ? ALE_CYC : RD_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, HOLD, READ, OUT, FIN} state_t;

    state_t      state_reg;
    logic [CW-1:0] cnt_reg;
    logic [10:0] cur_addr_reg;
    logic [11:0] remaining_reg;

    // Burst sequencer with registered bus and stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            cur_addr_reg   <= '0;
            remaining_reg  <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.byte_valid <= 1'b0;
            bus.byte_data  <= '0;
            bus.byte_addr  <= '0;
            bus.addr_dat   <= '0;
            bus.ad_oe      <= 1'b0;
            bus.ale        <= 1'b0;
            bus.rd_n       <= 1'b1;
            bus.ce         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        cur_addr_reg  <= bus.start_addr;
                        remaining_reg <= bus.count;
                        if (bus.count == 12'd0) begin
                            // empty burst: report completion without touching the socket
                            state_reg <= FIN;
                            bus.done  <= 1'b1;
                        end else begin
                            state_reg    <= ADDR;
                            bus.busy     <= 1'b1;
                            bus.ce       <= 1'b1;
                            bus.ad_oe    <= 1'b1;
                            bus.ale      <= 1'b1;
                            bus.addr_dat <= bus.start_addr;
                            cnt_reg      <= CW'(ALE_CYC - 1);
                        end
                    end
                end
                ADDR: begin
                    if (cnt_reg == '0) begin
                        // ALE falls, address stays on the pins for hold time
                        state_reg <= HOLD;
                        bus.ale   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    // release AD7-0 on the same edge RD_N goes low
                    state_reg <= READ;
                    bus.ad_oe <= 1'b0;
                    bus.rd_n  <= 1'b0;
                    cnt_reg   <= CW'(RD_CYC - 1);
                end
                READ: begin
                    if (cnt_reg == '0) begin
                        state_reg      <= OUT;
                        bus.rd_n       <= 1'b1;
                        bus.byte_data  <= bus.data_in;
                        bus.byte_addr  <= cur_addr_reg;
                        bus.byte_valid <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                OUT: begin
                    if (bus.byte_ready) begin
                        bus.byte_valid <= 1'b0;
                        remaining_reg  <= remaining_reg - 12'd1;
                        cur_addr_reg   <= cur_addr_reg + 11'd1;
                        if (remaining_reg == 12'd1) begin
                            state_reg <= FIN;
                            bus.done  <= 1'b1;
                            bus.busy  <= 1'b0;
                            bus.ce    <= 1'b0;
                        end else begin
                            state_reg    <= ADDR;
                            bus.ad_oe    <= 1'b1;
                            bus.ale      <= 1'b1;
                            bus.addr_dat <= cur_addr_reg + 11'd1;
                            cnt_reg      <= CW'(ALE_CYC - 1);
                        end
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    bus.done  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
